// File: rtl/dm_pkg.sv
// Shared types and sizes for the data-memory responder.
package dm_pkg;

    localparam int DM_WORDS = 32;
    localparam int DM_AW    = 5;
    localparam int DM_DW    = 32;
    localparam int DM_BE    = DM_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmStateT;

    // One accepted request, frozen for the life of the transaction.
    typedef struct packed {
        logic             we;
        logic [DM_AW-1:0] addr;
        logic [DM_DW-1:0] wd;
        logic [DM_BE-1:0] be;
    } dmReqT;

endpackage

// File: rtl/dm_wait_cnt.sv
// Wait-state down-counter: loads on acceptance, counts down in WAIT,
// flags terminal count when it holds 1 (last wait cycle).
module dm_wait_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] loadVal,
    input  logic          dec,
    output logic          tc
);

    logic [CW-1:0] cnt;

    // Counter register; saturates at zero so a stray dec cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == CW'(1));

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// 32 x 32-bit word memory, byte-enabled stores, registered outputs.
import dm_pkg::*;

module dm_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter bit INIT_ZERO   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [DM_AW-1:0] addressDM,
    input  logic [DM_DW-1:0] wd,
    input  logic [DM_BE-1:0] be,
    output logic [DM_DW-1:0] dm_Result,
    output logic             ready,
    output logic             busy
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    dmStateT          state, stateNext;
    dmReqT            cap, capNext;
    logic             accept;
    logic             tc;
    logic             wrEn;
    logic [DM_DW-1:0] dmNext;
    logic [DM_DW-1:0] mem [DM_WORDS];

    dm_wait_cnt #(.CW(4)) uWaitCnt (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .loadVal (WAIT_LD),
        .dec     (state == WAIT),
        .tc      (tc)
    );

    // Next-state, request capture and next load data.
    always_comb begin
        stateNext = state;
        capNext   = cap;
        accept    = 1'b0;
        dmNext    = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    capNext   = '{we: we, addr: addressDM, wd: wd, be: be};
                    stateNext = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT:    if (tc) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // Read uses the next capture so the zero-wait case sees the new address.
        if ((stateNext == RESP) && !capNext.we) begin
            dmNext = mem[capNext.addr];
        end
    end

    // State, capture and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cap       <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            dm_Result <= '0;
        end else begin
            state     <= stateNext;
            cap       <= capNext;
            ready     <= (stateNext == RESP);
            busy      <= (stateNext != IDLE);
            dm_Result <= dmNext;
        end
    end

    // Stores commit on the edge that ends RESP; reset forces IDLE first, so an
    // aborted request never writes.
    assign wrEn = (state == RESP) && cap.we;

    generate
        if (INIT_ZERO) begin : gMemRst
            // Memory with reset-to-zero.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
                end else if (wrEn) begin
                    for (int b = 0; b < DM_BE; b++)
                        if (cap.be[b]) mem[cap.addr][8*b +: 8] <= cap.wd[8*b +: 8];
                end
            end
        end else begin : gMemKeep
            // Memory contents survive reset.
            always_ff @(posedge clk) begin
                if (wrEn) begin
                    for (int b = 0; b < DM_BE; b++)
                        if (cap.be[b]) mem[cap.addr][8*b +: 8] <= cap.wd[8*b +: 8];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a 2-wait instance and a 0-wait instance
// share stimulus; a timeline model predicts both every cycle.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addressDM = '0;
    logic [31:0] wd = '0;
    logic [3:0]  be = '0;
    logic [31:0] dmA, dmB;
    logic        readyA, readyB, busyA, busyB;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_responder #(.WAIT_CYCLES(2), .INIT_ZERO(1'b1)) dutA (
        .clk(clk), .reset(reset), .req(req), .we(we), .addressDM(addressDM),
        .wd(wd), .be(be), .dm_Result(dmA), .ready(readyA), .busy(busyA)
    );

    dm_responder #(.WAIT_CYCLES(0), .INIT_ZERO(1'b1)) dutB (
        .clk(clk), .reset(reset), .req(req), .we(we), .addressDM(addressDM),
        .wd(wd), .be(be), .dm_Result(dmB), .ready(readyB), .busy(busyB)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // A request accepted while idle in cycle c responds in cycle c+W+1;
    // the instance is busy for cycles c+1..c+W+1; a store lands at the end
    // of its response cycle unless reset is low at that edge.
    int          wc [2] = '{2, 0};
    logic [31:0] mm [2][32];
    bit          act [2];
    int          rc [2];
    bit          cWe [2];
    logic [4:0]  cAd [2];
    logic [31:0] cWd [2];
    logic [3:0]  cBe [2];
    bit          wasAct;
    int          cyc = 0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                act[d] = 1'b0;
                for (int i = 0; i < 32; i++) mm[d][i] = '0;
            end else begin
                wasAct = act[d];
                if (act[d] && rc[d] == cyc) begin
                    if (cWe[d])
                        for (int b = 0; b < 4; b++)
                            if (cBe[d][b]) mm[d][cAd[d]][8*b +: 8] = cWd[d][8*b +: 8];
                    act[d] = 1'b0;
                end
                if (!wasAct && req) begin
                    act[d] = 1'b1;
                    rc[d]  = cyc + wc[d] + 1;
                    cWe[d] = we;
                    cAd[d] = addressDM;
                    cWd[d] = wd;
                    cBe[d] = be;
                end
            end
        end
        cyc++;
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        logic        eR, eB;
        logic [31:0] eD;
        for (int d = 0; d < 2; d++) begin
            eR = reset && act[d] && (rc[d] == cyc);
            eB = reset && act[d];
            eD = (eR && !cWe[d]) ? mm[d][cAd[d]] : 32'h0;
            if (d == 0) begin
                chk("A.ready", {31'b0, readyA}, {31'b0, eR});
                chk("A.busy",  {31'b0, busyA},  {31'b0, eB});
                chk("A.dm",    dmA, eD);
            end else begin
                chk("B.ready", {31'b0, readyB}, {31'b0, eR});
                chk("B.busy",  {31'b0, busyB},  {31'b0, eB});
                chk("B.dm",    dmB, eD);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // One transaction; inputs are scrambled right after the request cycle,
    // and the 2-wait instance must answer exactly 3 cycles after req.
    task automatic txn(input bit w, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] b, input string nm,
                       input bit chkData, input logic [31:0] expData);
        int n;
        @(posedge clk); #1;
        req = 1'b1; we = w; addressDM = a; wd = d; be = b;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; addressDM = 5'd9; wd = 32'hFFFFFFFF; be = 4'hF;
        n = 1;
        while (n < 12) begin
            @(negedge clk);
            if (readyA) break;
            n++;
        end
        chk({nm, ".latency"}, 32'(n), 32'd3);
        if (chkData) chk({nm, ".data"}, dmA, expData);
    endtask

    initial begin
        int nR, nBz, nTog;
        logic prevB;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.readyA", {31'b0, readyA}, 32'd0);
        chk("rst.busyA",  {31'b0, busyA},  32'd0);
        chk("rst.dmA",    dmA, 32'h0);
        chk("rst.busyB",  {31'b0, busyB},  32'd0);
        @(posedge clk); #1 reset = 1'b1;

        txn(1'b0, 5'd5,  32'h0,        4'h0,    "ld5",    1'b1, 32'h0);
        txn(1'b1, 5'd7,  32'hDEADBEEF, 4'hF,    "st7",    1'b0, 32'h0);
        txn(1'b0, 5'd7,  32'h0,        4'h0,    "ld7a",   1'b1, 32'hDEADBEEF);
        txn(1'b1, 5'd7,  32'h11223344, 4'b0101, "st7p",   1'b0, 32'h0);
        txn(1'b0, 5'd7,  32'h0,        4'h0,    "ld7b",   1'b1, 32'hDE22BE44);
        txn(1'b1, 5'd7,  32'h55555555, 4'b0000, "st7z",   1'b0, 32'h0);
        txn(1'b0, 5'd7,  32'h0,        4'h0,    "ld7c",   1'b1, 32'hDE22BE44);
        txn(1'b1, 5'd12, 32'hCAFEF00D, 4'hF,    "st12",   1'b0, 32'h0);
        txn(1'b0, 5'd12, 32'h0,        4'h0,    "ld12",   1'b1, 32'hCAFEF00D);
        txn(1'b0, 5'd9,  32'h0,        4'h0,    "ld9",    1'b1, 32'h0);
        txn(1'b0, 5'd31, 32'h0,        4'h0,    "ld31",   1'b1, 32'h0);

        // req held high: the zero-wait instance completes every other cycle.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addressDM = 5'd7;
        nR = 0; nBz = 0; nTog = 0; prevB = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (readyB) nR++;
            if (busyB) nBz++;
            if (i > 0 && busyB != prevB) nTog++;
            prevB = busyB;
        end
        chk("hold.readyB", 32'(nR), 32'd4);
        chk("hold.busyB",  32'(nBz), 32'd4);
        chk("hold.toggle", 32'(nTog), 32'd7);
        @(posedge clk); #1 req = 1'b0;
        repeat (6) @(posedge clk);

        // Reset during WAIT aborts the store and clears memory.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addressDM = 5'd3; wd = 32'hA5A5A5A5; be = 4'hF;
        @(posedge clk); #1;
        req = 1'b0; reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        nR = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (readyA) nR++;
        end
        chk("abort.noReady", 32'(nR), 32'd0);
        txn(1'b0, 5'd3, 32'h0, 4'h0, "ld3", 1'b1, 32'h0);
        txn(1'b0, 5'd7, 32'h0, 4'h0, "ld7r", 1'b1, 32'h0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
